// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded ID fields into EXE, inserts bubbles
// on branch flush or load-use interlock, and freezes on a global hold.
module id_exe_reg #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         hold,
    input  logic         flush,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic [W-1:0] id_rs_data,
    input  logic [W-1:0] id_rt_data,
    input  logic [W-1:0] id_imm,
    input  logic [W-1:0] id_pc4,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic         id_mem_to_reg,
    input  logic         id_alu_src,
    input  logic         id_reg_dst,
    input  logic [3:0]   id_alu_op,
    output logic [4:0]   exe_rs,
    output logic [4:0]   exe_rt,
    output logic [4:0]   exe_rd,
    output logic [W-1:0] exe_rs_data,
    output logic [W-1:0] exe_rt_data,
    output logic [W-1:0] exe_imm,
    output logic [W-1:0] exe_pc4,
    output logic         exe_reg_write,
    output logic         exe_mem_read,
    output logic         exe_mem_write,
    output logic         exe_mem_to_reg,
    output logic         exe_alu_src,
    output logic         exe_reg_dst,
    output logic [3:0]   exe_alu_op,
    output logic [4:0]   EXE_num_write,
    output logic         EXE_reg_write,
    output logic         stall,
    output logic         flush_pending
);

    typedef struct packed {
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [W-1:0] rs_data;
        logic [W-1:0] rt_data;
        logic [W-1:0] imm;
        logic [W-1:0] pc4;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
        logic         alu_src;
        logic         reg_dst;
        logic [3:0]   alu_op;
        logic [4:0]   num_write;
    } exe_t;

    localparam exe_t BUBBLE = '0;

    exe_t exe_d, exe_q;
    exe_t id_entry_s;
    logic flush_pending_d, flush_pending_q;
    logic stall_s;

    // Assemble the incoming ID entry, including its resolved destination register.
    always_comb begin
        id_entry_s            = BUBBLE;
        id_entry_s.rs         = id_rs;
        id_entry_s.rt         = id_rt;
        id_entry_s.rd         = id_rd;
        id_entry_s.rs_data    = id_rs_data;
        id_entry_s.rt_data    = id_rt_data;
        id_entry_s.imm        = id_imm;
        id_entry_s.pc4        = id_pc4;
        id_entry_s.reg_write  = id_reg_write;
        id_entry_s.mem_read   = id_mem_read;
        id_entry_s.mem_write  = id_mem_write;
        id_entry_s.mem_to_reg = id_mem_to_reg;
        id_entry_s.alu_src    = id_alu_src;
        id_entry_s.reg_dst    = id_reg_dst;
        id_entry_s.alu_op     = id_alu_op;
        if (id_reg_dst) begin
            id_entry_s.num_write = id_rd;
        end else begin
            id_entry_s.num_write = id_rt;
        end
    end

    // Load-use interlock; $0 is hardwired so it can never be a hazard source.
    assign stall_s = exe_q.mem_read & (exe_q.num_write != 5'd0) &
                     ((exe_q.num_write == id_rs) | (exe_q.num_write == id_rt));

    // Next-state selection: hold, then flush, then interlock bubble, then capture.
    always_comb begin
        exe_d           = exe_q;
        flush_pending_d = flush_pending_q;
        if (hold) begin
            exe_d           = exe_q;
            flush_pending_d = flush_pending_q | flush;
        end else if (flush | flush_pending_q) begin
            exe_d           = BUBBLE;
            flush_pending_d = 1'b0;
        end else if (stall_s) begin
            exe_d           = BUBBLE;
            flush_pending_d = 1'b0;
        end else begin
            exe_d           = id_entry_s;
            flush_pending_d = 1'b0;
        end
    end

    // Pipeline state flops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exe_q           <= BUBBLE;
            flush_pending_q <= 1'b0;
        end else begin
            exe_q           <= exe_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign exe_rs         = exe_q.rs;
    assign exe_rt         = exe_q.rt;
    assign exe_rd         = exe_q.rd;
    assign exe_rs_data    = exe_q.rs_data;
    assign exe_rt_data    = exe_q.rt_data;
    assign exe_imm        = exe_q.imm;
    assign exe_pc4        = exe_q.pc4;
    assign exe_reg_write  = exe_q.reg_write;
    assign exe_mem_read   = exe_q.mem_read;
    assign exe_mem_write  = exe_q.mem_write;
    assign exe_mem_to_reg = exe_q.mem_to_reg;
    assign exe_alu_src    = exe_q.alu_src;
    assign exe_reg_dst    = exe_q.reg_dst;
    assign exe_alu_op     = exe_q.alu_op;
    assign EXE_num_write  = exe_q.num_write;
    assign EXE_reg_write  = exe_q.reg_write;
    assign stall          = stall_s;
    assign flush_pending  = flush_pending_q;

endmodule
